// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
//   Bank of CH independent programmable timers. While enabled, each channel
//   counts 0..div and then wraps, producing a one-cycle tick and toggling its
//   divided square-wave output. Divisors are written one channel at a time
//   through a load strobe, which is acknowledged (or flagged as an error when
//   the channel index does not exist).
//
//   Optional feature (macro MULTI_TIMER_SYNC_EN):
//     when defined, a sync strobe restarts every channel's phase
//     (counter and clk_out cleared, no tick). When undefined, sync is ignored.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   [CH]     per-channel count enable
//   load      in   1        divisor-load strobe
//   load_ch   in   [4]      channel index for load
//   load_div  in   [CNT_W]  divisor value for load
//   sync      in   1        phase-restart strobe (MULTI_TIMER_SYNC_EN only)
//   load_ack  out  1        one-cycle acknowledge of an accepted load
//   load_err  out  1        one-cycle flag for a load to a missing channel
//   tick      out  [CH]     one-cycle terminal-count pulse per channel
//   clk_out   out  [CH]     divided square wave, half-period div+1 cycles
// -----------------------------------------------------------------------------
module multi_timer #(
  parameter int CH      = 4,
  parameter int CNT_W   = 20,
  parameter int DEF_DIV = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    en,
  input  logic             load,
  input  logic [3:0]       load_ch,
  input  logic [CNT_W-1:0] load_div,
  input  logic             sync,
  output logic             load_ack,
  output logic             load_err,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    clk_out
);

  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];
  logic [CNT_W-1:0] div_q [CH];
  logic [CNT_W-1:0] div_d [CH];
  logic [CH-1:0]    clk_q, clk_d;
  logic [CH-1:0]    tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [CH-1:0]    ld_hit;
  logic             sync_act;

`ifdef MULTI_TIMER_SYNC_EN
  assign sync_act = sync;
`else
  // sync is deliberately left dangling; the constant below folds away all
  // restart logic.
  logic unused_sync;
  assign unused_sync = sync;
  assign sync_act    = 1'b0;
`endif

  // Decode by equality against each existing channel, so an index >= CH
  // simply matches nothing and never indexes past the arrays.
  always_comb begin
    ld_hit = '0;
    for (int i = 0; i < CH; i++) begin
      ld_hit[i] = load && (load_ch == 4'(i));
    end
  end

  assign ack_d = |ld_hit;
  assign err_d = load && !(|ld_hit);

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    clk_d  = clk_q;
    tick_d = '0;
    for (int i = 0; i < CH; i++) begin
      if (ld_hit[i]) begin
        // Load wins over a coincident terminal count: no tick, no toggle.
        div_d[i] = load_div;
        cnt_d[i] = '0;
        if (sync_act) clk_d[i] = 1'b0;
      end else if (sync_act) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
      end else if (en[i]) begin
        if (cnt_q[i] == div_q[i]) begin
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= CNT_W'(DEF_DIV);
      end
      clk_q  <= '0;
      tick_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end
  end

  assign load_ack = ack_q;
  assign load_err = err_q;
  assign tick     = tick_q;
  assign clk_out  = clk_q;

endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;

  localparam int CH      = 4;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 20;

  logic             clk;
  logic             rst_n;
  logic [CH-1:0]    en;
  logic             load;
  logic [3:0]       load_ch;
  logic [CNT_W-1:0] load_div;
  logic             sync;
  logic             load_ack;
  logic             load_err;
  logic [CH-1:0]    tick;
  logic [CH-1:0]    clk_out;

  int errors = 0;
  int checks = 0;
  logic [CH-1:0] seen;

  multi_timer #(.CH(CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_ch  (load_ch),
    .load_div (load_div),
    .sync     (sync),
    .load_ack (load_ack),
    .load_err (load_err),
    .tick     (tick),
    .clk_out  (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_load(input logic [3:0] ch, input logic [CNT_W-1:0] dv);
    load     = 1'b1;
    load_ch  = ch;
    load_div = dv;
  endtask

  initial begin
    rst_n = 1'b1; en = '0; load = 1'b0; load_ch = '0; load_div = '0; sync = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_ack", load_ack, 0);
    chk("rst_err", load_err, 0);

    // First terminal count from default divisor: DEF_DIV+1 cycles
    #10 rst_n = 1'b1;
    en = 4'b0001;
    seen = '0;
    for (int i = 0; i < DEF_DIV; i++) begin cyc(); seen |= tick; end
    chk("def_no_early_tick", seen, 0);
    cyc();
    chk("def_tick", tick, 4'b0001);
    chk("def_clk_out", clk_out, 4'b0001);

    // ch0 div=3: ack next cycle, tick every 4, clk_out period 8
    do_load(0, 3);
    cyc();
    chk("ld0_ack", load_ack, 1);
    chk("ld0_err", load_err, 0);
    load = 1'b0;
    repeat (3) cyc();
    chk("d3_no_tick_c3", tick, 0);
    cyc();
    chk("d3_tick_c4", tick, 4'b0001);
    chk("d3_clk_c4", clk_out, 4'b0000);
    repeat (3) cyc();
    chk("d3_no_tick_c7", tick, 0);
    cyc();
    chk("d3_tick_c8", tick, 4'b0001);
    chk("d3_clk_c8", clk_out, 4'b0001);

    // ch1 div=0: tick every cycle, clk_out toggles every cycle
    en = 4'b0010;
    do_load(1, 0);
    cyc();
    chk("ld1_ack", load_ack, 1);
    load = 1'b0;
    cyc();
    chk("d0_tick_a", tick, 4'b0010);
    chk("d0_clk_a", clk_out, 4'b0011);
    cyc();
    chk("d0_tick_b", tick, 4'b0010);
    chk("d0_clk_b", clk_out, 4'b0001);

    // Load to nonexistent channel 7
    do_load(7, 9);
    cyc();
    chk("bad_err", load_err, 1);
    chk("bad_ack", load_ack, 0);
    chk("bad_ch1_tick", tick, 4'b0010);
    load = 1'b0;
    cyc();
    chk("bad_err_clear", load_err, 0);
    chk("bad_div_kept", tick, 4'b0010);

    // Back-to-back loads
    en = 4'b0000;
    do_load(2, 5);
    cyc();
    chk("b2b_ack1", load_ack, 1);
    do_load(3, 6);
    cyc();
    chk("b2b_ack2", load_ack, 1);
    load = 1'b0;
    cyc();
    chk("b2b_ack_clear", load_ack, 0);

    // Load at terminal count: load wins
    en = 4'b0001;
    do_load(0, 5);
    cyc();
    load = 1'b0;
    repeat (5) cyc();
    chk("tc_pre_no_tick", tick, 0);
    do_load(0, 2);
    cyc();
    chk("tc_load_no_tick", tick, 0);
    chk("tc_load_ack", load_ack, 1);
    chk("tc_clk_unchanged", clk_out, 4'b0001);
    load = 1'b0;
    repeat (2) cyc();
    chk("tc_no_tick_c2", tick, 0);
    cyc();
    chk("tc_tick_c3", tick, 4'b0001);
    chk("tc_clk_c3", clk_out, 4'b0000);

    // Enable gap on ch2 delays tick by exactly the gap
    en = 4'b0100;
    do_load(2, 4);
    cyc();
    load = 1'b0;
    repeat (2) cyc();
    en = 4'b0000;
    seen = '0;
    for (int i = 0; i < 10; i++) begin cyc(); seen |= tick; end
    chk("gap_no_tick", seen, 0);
    chk("gap_clk_held", clk_out, 4'b0000);
    en = 4'b0100;
    repeat (2) cyc();
    chk("gap_resume_no_tick", tick, 0);
    cyc();
    chk("gap_resume_tick", tick, 4'b0100);
    chk("gap_resume_clk", clk_out, 4'b0100);

    // Reset mid-count and mid-load
    repeat (2) cyc();
    do_load(0, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_clk", clk_out, 0);
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_ack", load_ack, 0);
    load = 1'b0;
    en = 4'b0001;
    #2 rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < DEF_DIV; i++) begin cyc(); seen |= tick; end
    chk("mid_rst_div_restored", seen, 0);
    cyc();
    chk("mid_rst_def_tick", tick, 4'b0001);

    // Sync pulse with channels at different phases
    en = 4'b0000;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    do_load(0, 3);
    cyc();
    do_load(1, 2);
    cyc();
    load = 1'b0;
    en = 4'b0011;
    repeat (5) cyc();
    chk("sync_pre_clk", clk_out, 4'b0011);
    sync = 1'b1;
    do_load(3, 1);
    cyc();
    chk("sync_ack", load_ack, 1);
`ifdef MULTI_TIMER_SYNC_EN
    chk("sync_clk", clk_out, 4'b0000);
    chk("sync_tick", tick, 4'b0000);
`else
    chk("nosync_clk", clk_out, 4'b0001);
    chk("nosync_tick", tick, 4'b0010);
`endif
    sync = 1'b0;
    load = 1'b0;
    repeat (2) cyc();
`ifdef MULTI_TIMER_SYNC_EN
    chk("sync_phase", tick, 4'b0000);
`else
    chk("nosync_phase", tick, 4'b0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
